// File: rtl/playbus_pkg.sv
// playbus_pkg: shared types and constants for the PlayBus initiator.
//   ADDR_W_DEF      - default RAM/ROM address width (also block length width)
//   playbus_op_t    - transfer command encoding (source/sink pair)
//   playbus_state_t - bus sequencing phases
package playbus_pkg;

  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    SW_TO_LED  = 2'b00,
    SW_TO_RAM  = 2'b01,
    ROM_TO_RAM = 2'b10,
    RAM_TO_LED = 2'b11
  } playbus_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    STROBE = 2'b10,
    HOLD   = 2'b11
  } playbus_state_t;

endpackage

// File: rtl/playbus_strobe_decode.sv
// playbus_strobe_decode: purely combinational decode of the registered
// (op, state) pair into the five PlayBus strobes.
// Ports:
//   op_i      - registered transfer op
//   state_i   - registered sequencer state
//   ramo_o, romo_o, swben_o - source output enables (exactly one while active)
//   ramw_o, ledltch_o       - sink strobes (only in STROBE)
module playbus_strobe_decode
  import playbus_pkg::*;
(
  input  playbus_op_t    op_i,
  input  playbus_state_t state_i,
  output logic           ramo_o,
  output logic           romo_o,
  output logic           swben_o,
  output logic           ramw_o,
  output logic           ledltch_o
);

  logic active;
  logic strobe;

  assign active = (state_i != IDLE);
  assign strobe = (state_i == STROBE);

  always_comb begin
    ramo_o    = 1'b0;
    romo_o    = 1'b0;
    swben_o   = 1'b0;
    ramw_o    = 1'b0;
    ledltch_o = 1'b0;
    // Each op selects exactly one source and one sink, so the source enable
    // is one-hot by construction and the sink only fires under its source.
    unique case (op_i)
      SW_TO_LED: begin
        swben_o   = active;
        ledltch_o = strobe;
      end
      SW_TO_RAM: begin
        swben_o = active;
        ramw_o  = strobe;
      end
      ROM_TO_RAM: begin
        romo_o = active;
        ramw_o = strobe;
      end
      RAM_TO_LED: begin
        ramo_o    = active;
        ledltch_o = strobe;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/playbus_ctrl.sv
// playbus_ctrl: PlayBus bus initiator. Accepts a transfer command and runs a
// SETUP/STROBE/HOLD sequence per nibble, driving one source enable and one
// sink strobe so that two bus drivers are never enabled together.
// Optional feature macro: PLAYBUS_BLOCK_EN (block transfers of cmd_len+1
// nibbles with auto-incrementing addr); undefined = one transfer per command.
// Ports:
//   n_clk, reset         - clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready  - command handshake (ready == IDLE)
//   cmd_op, cmd_addr, cmd_len - command fields, captured on accept
//   abort                - synchronous abort request while busy
//   RAMO, ROMO, SWBEN    - source enables
//   RAMW, LEDLTCH        - sink strobes
//   addr                 - current RAM/ROM address
//   busy, done           - not-IDLE flag, one-cycle normal-completion pulse
module playbus_ctrl
  import playbus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              n_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              abort,
  output logic              RAMO,
  output logic              ROMO,
  output logic              SWBEN,
  output logic              RAMW,
  output logic              LEDLTCH,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  playbus_state_t    state_q, state_d;
  playbus_op_t       op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              abrt_q, abrt_d;
  logic              done_q, done_d;
  logic              last;
  logic              accept;

  assign accept = cmd_valid && (state_q == IDLE);

`ifdef PLAYBUS_BLOCK_EN
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cmd_len;
    end else if (state_q == HOLD && !abort && !abrt_q && !last) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge n_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_len;

  assign unused_len = ^cmd_len;
  assign last       = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    abrt_d  = abrt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        abrt_d = 1'b0;
        // abort is ignored here: a simultaneous command is still taken.
        if (cmd_valid) begin
          state_d = SETUP;
          op_d    = playbus_op_t'(cmd_op);
          addr_d  = cmd_addr;
        end
      end
      SETUP: begin
        state_d = abort ? IDLE : STROBE;
      end
      STROBE: begin
        // The strobe in flight always completes; remember the abort so HOLD
        // ends the command instead of starting the next transfer.
        state_d = HOLD;
        if (abort) begin
          abrt_d = 1'b1;
        end
      end
      HOLD: begin
        if (abort || abrt_q) begin
          state_d = IDLE;
          abrt_d  = 1'b0;
        end else if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SETUP;
          addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge n_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= SW_TO_LED;
      addr_q  <= '0;
      abrt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      abrt_q  <= abrt_d;
      done_q  <= done_d;
    end
  end

  playbus_strobe_decode u_decode (
    .op_i      (op_q),
    .state_i   (state_q),
    .ramo_o    (RAMO),
    .romo_o    (ROMO),
    .swben_o   (SWBEN),
    .ramw_o    (RAMW),
    .ledltch_o (LEDLTCH)
  );

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign addr      = addr_q;

endmodule
